// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit:
// operation encodings and the control FSM state type.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration: shift-add for multiply (multiplier held
// in the low half, consumed LSB first), restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_is_div,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
    w_shifted = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = w_shifted - {1'b0, i_operand};
    o_acc     = i_acc;
    o_qbit    = 1'b0;
    if (i_is_div) begin
      // The partial remainder is always below the divisor, so no borrow means
      // the shifted remainder fits and the difference needs only WIDTH bits.
      o_qbit = ~w_diff[WIDTH];
      if (o_qbit) o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      else        o_acc = {w_shifted[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle signed/unsigned multiply/divide with architectural HI/LO registers.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t r_state, w_next_state;

  logic [2*WIDTH-1:0] r_acc, w_acc_next, w_prod_raw, w_prod;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo, w_mag_a, w_mag_b, w_quot, w_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic r_is_div, r_neg, r_neg_rem, r_dbz;
  logic w_idle, w_is_div, w_signed, w_div_zero, w_calc_last, w_qbit;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .i_is_div  (r_is_div),
    .o_acc     (w_acc_next),
    .o_qbit    (w_qbit)
  );

  always_comb begin
    w_idle     = (r_state == IDLE) || (r_state == DONE);
    w_is_div   = op[1];
    w_signed   = ~op[0];
    w_div_zero = w_is_div && (b == '0);
    w_mag_a    = (w_signed && a[WIDTH-1]) ? -a : a;
    w_mag_b    = (w_signed && b[WIDTH-1]) ? -b : b;
    w_calc_last = (r_cnt == CNT_W'(1));
`ifdef MULDIV_EARLY_TERM_EN
    // After this step only the low r_cnt-1 bits still hold unprocessed multiplier.
    if (!r_is_div &&
        ((w_acc_next[WIDTH-1:0] & ~({WIDTH{1'b1}} << (r_cnt - CNT_W'(1)))) == '0))
      w_calc_last = 1'b1;
    w_prod_raw = r_acc >> r_cnt;
`else
    w_prod_raw = r_acc;
`endif
    w_prod = r_neg     ? -w_prod_raw : w_prod_raw;
    w_quot = r_neg     ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_next_state = w_div_zero ? DONE : CALC;
        else       w_next_state = IDLE;
      end
      CALC:    if (w_calc_last) w_next_state = FIX;
      FIX:     w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == CALC) || (r_state == FIX);
    done        = (r_state == DONE);
    div_by_zero = (r_state == DONE) && r_dbz;
    hi          = r_hi;
    lo          = r_lo;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (wr_hi) r_hi <= wr_data;
          if (wr_lo) r_lo <= wr_data;
          if (start) begin
            r_dbz     <= w_div_zero;
            r_is_div  <= w_is_div;
            r_neg     <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem <= w_signed && a[WIDTH-1];
            r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_cnt     <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          r_acc <= w_acc_next | {{(2*WIDTH-1){1'b0}}, w_qbit};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          if (r_is_div) begin
            r_lo <= w_quot;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level arithmetic reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: {hi, lo} for a completed operation.
  function automatic logic [63:0] modelResult(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint       sx, sy, q, r;
    logic [63:0]  res, qv, rv;
    sx = $signed(x);
    sy = $signed(y);
    res = '0;
    case (o)
      OP_MULT:  res = sx * sy;
      OP_MULTU: res = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        q = sx / sy;
        r = sx % sy;
        qv = q;
        rv = r;
        res = {rv[31:0], qv[31:0]};
      end
      default:  res = {x % y, x / y};
    endcase
    return res;
  endfunction

  // Cycle-level model: busy for W+1 cycles after an accepted start, then one done cycle.
  int           mLeft;
  logic [W-1:0] mHi, mLo, mResHi, mResLo;
  logic         mDone, mDbz;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mLeft = 0; mHi = '0; mLo = '0; mResHi = '0; mResLo = '0; mDone = 0; mDbz = 0;
    end else begin
      mDone = 0;
      mDbz  = 0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mHi = mResHi;
          mLo = mResLo;
          mDone = 1;
        end
      end else begin
        if (wr_hi) mHi = wr_data;
        if (wr_lo) mLo = wr_data;
        if (start) begin
          if (op[1] && b == '0) begin
            mDone = 1;
            mDbz  = 1;
          end else begin
            {mResHi, mResLo} = modelResult(op, a, b);
            mLeft = W + 1;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      checkOutput("cyc_busy", 64'(busy), 64'(mLeft > 0));
      checkOutput("cyc_done", 64'(done), 64'(mDone));
      checkOutput("cyc_dbz",  64'(div_by_zero), 64'(mDbz));
      checkOutput("cyc_hi",   64'(hi), 64'(mHi));
      checkOutput("cyc_lo",   64'(lo), 64'(mLo));
    end
  end

  // Starts an operation at a falling edge and returns at the falling edge inside the done cycle.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input int injectAt, output int lat);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == injectAt) begin
        start = 1'b1; op = OP_DIV; a = 9; b = 3; wr_lo = 1'b1; wr_data = 'hAAAA;
      end
      @(negedge clock);
      lat++;
      start = 1'b0; wr_lo = 1'b0;
    end
    if (done !== 1'b1) checkOutput("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  int lat;
  int seenDone;

  initial begin
    idleCycles(2);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_done", 64'(done), 0);
    checkOutput("rst_dbz",  64'(div_by_zero), 0);
    checkOutput("rst_hi",   64'(hi), 0);
    checkOutput("rst_lo",   64'(lo), 0);
    reset = 1'b1;
    idleCycles(2);

    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 0, lat);
    checkOutput("t1_lat",  64'(lat), 64'(34));
    checkOutput("t1_hi",   64'(hi), 64'hFFFFFFFF);
    checkOutput("t1_lo",   64'(lo), 64'hFFFFFFEB);
    checkOutput("t1_busy", 64'(busy), 0);
    idleCycles(2);

    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat);
    checkOutput("t2_hi", 64'(hi), 64'hFFFFFFFE);
    checkOutput("t2_lo", 64'(lo), 64'h00000001);
    applyStimulus(OP_DIVU, 32'd7, 32'd2, 0, lat);
    checkOutput("t2_b2b_lat", 64'(lat), 64'(34));
    checkOutput("t2_divu_lo", 64'(lo), 64'd3);
    checkOutput("t2_divu_hi", 64'(hi), 64'd1);
    idleCycles(2);

    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, lat);
    checkOutput("t3_lo", 64'(lo), 64'hFFFFFFFD);
    checkOutput("t3_hi", 64'(hi), 64'hFFFFFFFF);
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, lat);
    checkOutput("t3_ovf_lo", 64'(lo), 64'h80000000);
    checkOutput("t3_ovf_hi", 64'(hi), 64'h0);
    checkOutput("t3_ovf_dbz", 64'(div_by_zero), 0);
    idleCycles(1);

    wr_hi = 1'b1; wr_data = 'h1234;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 'h5678;
    @(negedge clock);
    wr_lo = 1'b0;
    checkOutput("t4_mthi", 64'(hi), 64'h1234);
    checkOutput("t4_mtlo", 64'(lo), 64'h5678);
    applyStimulus(OP_DIV, 32'd5, 32'd0, 0, lat);
    checkOutput("t4_lat", 64'(lat), 64'(1));
    checkOutput("t4_dbz", 64'(div_by_zero), 1);
    checkOutput("t4_hi",  64'(hi), 64'h1234);
    checkOutput("t4_lo",  64'(lo), 64'h5678);
    idleCycles(2);

    applyStimulus(OP_MULT, 32'd3, 32'd4, 5, lat);
    checkOutput("t5_lat", 64'(lat), 64'(34));
    checkOutput("t5_hi",  64'(hi), 64'h0);
    checkOutput("t5_lo",  64'(lo), 64'd12);
    idleCycles(1);

    applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE, 0, lat);
    checkOutput("x_div_lo", 64'(lo), 64'hFFFFFFFD);
    checkOutput("x_div_hi", 64'(hi), 64'd1);
    applyStimulus(OP_MULTU, 32'h00010000, 32'h00010000, 0, lat);
    checkOutput("x_mulu_hi", 64'(hi), 64'd1);
    checkOutput("x_mulu_lo", 64'(lo), 64'd0);
    applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, lat);
    checkOutput("x_mul_hi", 64'(hi), 64'd0);
    checkOutput("x_mul_lo", 64'(lo), 64'd6);
    idleCycles(2);

    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    idleCycles(9);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_busy", 64'(busy), 0);
    checkOutput("t6_done", 64'(done), 0);
    checkOutput("t6_hi",   64'(hi), 0);
    checkOutput("t6_lo",   64'(lo), 0);
    @(negedge clock);
    reset = 1'b1;
    seenDone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) seenDone++;
    end
    checkOutput("t6_no_done", 64'(seenDone), 0);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 0, lat);
    checkOutput("t6_after_lo", 64'(lo), 64'd14);
    checkOutput("t6_after_hi", 64'(hi), 64'd2);
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multicycle multiply/divide unit with architectural HI/LO registers for the multicycle MIPS-style datapath. It replaces the separate fixed 32-bit multiplier and divisor plus the HI/LO result registers. The control FSM drives it with a start/done handshake; HI/LO feed the register-data mux for MFHI/MFLO. It adds signed/unsigned modes, MTHI/MTLO writes and parametric width.

Parameters:
WIDTH, 32, operand and HI/LO width; must be at least 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  operation request; sampled only when idle (IDLE or DONE).
op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
a  in  WIDTH  rs operand: multiplicand or dividend.
b  in  WIDTH  rt operand: multiplier or divisor.
wr_hi  in  1  MTHI write strobe.
wr_lo  in  1  MTLO write strobe.
wr_data  in  WIDTH  MTHI/MTLO data.
busy  out  1  high in CALC and FIX.
done  out  1  one-cycle completion pulse.
div_by_zero  out  1  pulses with done when DIV/DIVU has b==0.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy, done, div_by_zero = 0; hi = lo = 0; counter and internal registers cleared. Reset mid-operation aborts it with no result written.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start==1, multiply or nonzero divisor: latch |a| and |b| (signed ops) or raw a and b (unsigned ops), latch the result sign, counter=WIDTH, go to CALC.
- IDLE/DONE with start==1, divide with b==0: go directly to DONE with div_by_zero=1; hi and lo are unchanged.
- CALC: one radix-2 step per cycle; decrement counter; go to FIX after WIDTH cycles.
  - Multiply step: shift-add into a 2*WIDTH accumulator.
  - Divide step: restoring shift-subtract.
- FIX, one cycle: apply sign correction, write hi/lo, go to DONE.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: quotient truncates toward zero (negated if signs differ); remainder takes the dividend's sign.
  - Multiply: hi gets the upper product half, lo the lower half.
  - Divide: lo gets the quotient, hi the remainder.
- DONE: done=1 for exactly one cycle. It is an idle state, so a start accepted here gives back-to-back operation. With no start, return to IDLE.
- Latency: start sampled at edge E0 → done high in the cycle after edge E(WIDTH+1), i.e. WIDTH+2 cycles. hi/lo are valid from the cycle done is high. Divide by zero: done in the cycle after E0.
- Overflow case: DIV of MIN by -1 gives lo=MIN, hi=0, with no flag.
- start while busy is ignored, with no queueing.
- wr_hi/wr_lo write only when not busy. While busy they are dropped.
- A write coincident with an accepted start is applied, and is later overwritten by the result.
- A write coincident with the FIX edge is impossible because busy==1 then.
- a, b and op are sampled only at the accept edge; later changes have no effect.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: MULT/MULTU leave CALC as soon as the remaining unprocessed multiplier bits are all zero (minimum 1 CALC cycle). Latency becomes variable, between 3 and WIDTH+2 cycles. Divide latency is unchanged.
- Undefined: fixed latency as above. Results are identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding localparams: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the FSM state typedef/enum: IDLE, CALC, FIX, DONE.
- Sub-module muldiv_step: combinational single iteration. Inputs are the accumulator, operand and mode; outputs are the next accumulator and quotient bit. It is instantiated once in muldiv_unit.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD, b=7 → done exactly 34 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low in the done cycle.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then start DIVU a=7, b=2 in the DONE cycle → accepted; lo=3, hi=1.
3. DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. MTHI 0x1234 and MTLO 0x5678, then DIV a=5, b=0 → done and div_by_zero high one cycle after the start edge; hi=0x1234, lo=0x5678 retained.
5. Start MULT 3×4; at cycle 5 pulse start (DIV 9/3) and wr_lo=0xAAAA → both ignored; result hi=0, lo=12, with done at cycle 34.
6. Start DIVU 100/7; drive reset low at cycle 10 → immediately busy=0, done=0, hi=lo=0. After reset release no done appears until a new start.
